z80_bus_uart: RTL
=================

# z80_bus_uart

Memory-bus stage between the Z80 core and its 64 KiB synchronous RAM. It forwards CPU accesses to RAM, except for a 4-byte window at 0xFFF0–0xFFF3, which it decodes as a memory-mapped 8N1 UART transmitter with a transmit FIFO. Read data returns with the same one-cycle latency as the RAM, so the core sees one uniform memory. It runs on the memory clock.

## Interface
- `FIFO_DEPTH`, 4: transmit FIFO entries; power of two, ≥2.
- `BAUD_DIV`, 433: reset value of the 16-bit divisor; bit period = divisor+1 clocks.
- `clock` in 1: memory/system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `address` in 16: CPU address.
- `data_i` in 8: CPU write data (core `data_o`).
- `we` in 1: CPU write strobe.
- `data_o` out 8: read data to CPU (core `data_i`).
- `ram_address` out 16: equals `address`, combinational.
- `ram_data_o` out 8: equals `data_i`, combinational.
- `ram_we` out 1: `we` and address outside 0xFFF0–0xFFF3.
- `ram_data_i` in 8: RAM read data; valid one clock after `ram_address`.
- `tx` out 1: serial output; idles high.

## Operation
- Window decode: `address[15:2] == 14'h3FFC`. Inside the window, the RAM is never written. Outside the window, `data_o` carries RAM data.
- 0xFFF0 TXDATA:
  - Write pushes `data_i[7:0]`.
  - Push when full: byte dropped, `ovf` set.
  - Read returns 0x00.
- 0xFFF1 STATUS (read-only):
  - Layout `{4'b0, ovf, busy, empty, full}`.
  - `busy` = shifter not IDLE.
  - Any read cycle of 0xFFF1 clears `ovf` at the clock edge, unless a dropping push happens in the same cycle; the set wins.
- 0xFFF2 DIVLO, 0xFFF3 DIVHI: read/write halves of the 16-bit divisor.
- The window is byte-decoded per cycle. A write held for N cycles acts N times; for TXDATA that means N pushes. The core asserts `we` for one memory clock per write.
- FIFO:
  - Circular buffer with `log2(FIFO_DEPTH)+1`-bit read/write pointers; wrap is by pointer overflow.
  - `full` when pointer MSBs differ and the rest match; `empty` when the pointers are equal.
  - Push and pop in the same cycle: both happen, count unchanged. This also applies when full, since the pop frees the slot: the push is accepted and `ovf` is not set.
  - Pop when empty never occurs; the shifter only pops when `!empty`.
- Transmitter state machine (bits LSB first):
  - IDLE: `tx`=1. If `!empty`: pop the head byte into the shift register, latch the divisor into the bit counter, go to START.
  - START: `tx`=0 for one bit period, then DATA with bit index 0.
  - DATA: `tx`=shift[0] for one bit period each; shift right; after bit 7, go to STOP.
  - STOP: `tx`=1 for one bit period, then IDLE.
- A frame is 10 bit periods, and IDLE lasts at least one clock between frames.
- Writing the divisor mid-frame does not affect the current frame; the new value applies from the next START.

## Timing
- Reset values:
  - `tx`=1, state IDLE, FIFO empty (pointers 0), `ovf`=0, divisor=`BAUD_DIV`.
  - Read-select register points to RAM; `data_o` then shows `ram_data_i`.
- Read latency is one clock:
  - Window hit and register address are registered on every edge.
  - Register read data is registered in the same cycle.
  - `data_o` = registered hit ? registered register data : `ram_data_i`.
- Register writes take effect at the edge where `we` is sampled. A STATUS read in the next cycle reflects the push.
- Push to an empty FIFO while IDLE:
  - Edge N: push.
  - Edge N+1: pop; state becomes START.
  - `tx` falls after edge N+1, i.e. two clocks after the write cycle.
- Each bit period is exactly divisor+1 clocks; `tx` is driven straight from a register.
- Reset mid-frame:
  - `tx` high after the reset edge.
  - FIFO contents are discarded.
  - No partial frame resumes.

## Structure
- Package `z80_bus_pkg`:
  - Window base (0xFFF0) and register offsets.
  - STATUS bit indices.
  - Transmitter state enum `{IDLE, START, DATA, STOP}`.
- Sub-module `z80_tx_fifo`:
  - Parameter `FIFO_DEPTH`; 8-bit data.
  - Signals push/pop/din/dout/full/empty.
  - Synchronous reset.
- Top-level holds the decode, registers, read mux and transmitter.

## Test plan
- Reset with `BAUD_DIV`=3:
  - `tx`=1; STATUS reads 0x02.
  - Write 0x5A to 0x1234, then read 0x1234 → 0x5A; `ram_we` was high for that cycle.
- Write 0xA5 to 0xFFF0 with divisor 3:
  - `tx` low two clocks later for 4 clocks.
  - Then bits 1,0,1,0,0,1,0,1 for 4 clocks each, then high.
  - STATUS shows `busy` during the frame.
- Write five bytes back-to-back (`FIFO_DEPTH`=4, transmitter idle):
  - The first byte pops, so no `ovf`.
  - A sixth write during frame 1 sets `ovf` (STATUS 0x0D pattern with `full`).
  - A STATUS read clears it; the following read shows bit3=0.
- Write 0x00 to 0xFFF2 and 0x00 to 0xFFF3 mid-frame:
  - The current frame keeps its old timing.
  - The next frame has 1-clock bits.
- Write 0x77 to 0xFFF0:
  - `ram_we` stays 0.
  - The RAM byte at 0xFFF0 is unchanged; a read of 0xFFF0 returns 0x00.
- Assert `reset` during DATA bit 3 with 2 bytes queued:
  - `tx`=1 next clock; STATUS=0x02.
  - No further start bits.

Source files
------------

// File: rtl/z80_bus_pkg.sv
// Shared constants for the Z80 memory-bus stage: UART window decode, STATUS
// layout and transmitter states.
package z80_bus_pkg;

   localparam logic [15:0] WIN_BASE = 16'hFFF0;

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_DIVLO  = 2'd2;
   localparam logic [1:0] OFF_DIVHI  = 2'd3;

   localparam int unsigned STAT_FULL  = 0;
   localparam int unsigned STAT_EMPTY = 1;
   localparam int unsigned STAT_BUSY  = 2;
   localparam int unsigned STAT_OVF   = 3;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

endpackage

// File: rtl/z80_tx_fifo.sv
// Byte-wide transmit FIFO; extra pointer MSB tells full from empty.
// A push while full is only accepted when a pop frees the slot in the same cycle.
module z80_tx_fifo #(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  logic       pop_i,
   input  logic [7:0] din_i,
   output logic [7:0] dout_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0] wptr_q, rptr_q;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic        do_push, do_pop;

   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o = (wptr_q == rptr_q);
   assign dout_o  = mem_q[rptr_q[AW-1:0]];

   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/z80_bus_uart.sv
// Z80 memory-bus stage: passes accesses to RAM and maps an 8N1 UART transmitter
// at 0xFFF0-0xFFF3, with read data aligned to the RAM's one-cycle latency.
module z80_bus_uart
   import z80_bus_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned BAUD_DIV   = 433
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] address,
   input  logic [7:0]  data_i,
   input  logic        we,
   output logic [7:0]  data_o,
   output logic [15:0] ram_address,
   output logic [7:0]  ram_data_o,
   output logic        ram_we,
   input  logic [7:0]  ram_data_i,
   output logic        tx
);

   logic       win_hit, wr_tx, rd_status, drop, pop;
   logic [1:0] offset;
   logic [7:0] fifo_dout, status;
   logic       fifo_full, fifo_empty;

   logic        hit_q;
   logic [7:0]  rdata_q, rdata_d;
   logic        ovf_q, ovf_d;
   logic [15:0] div_q, div_d;

   tx_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d, fdiv_q, fdiv_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_q, bit_d;
   logic        tx_q, tx_d;

   assign win_hit     = (address[15:2] == WIN_BASE[15:2]);
   assign offset      = address[1:0];
   assign ram_address = address;
   assign ram_data_o  = data_i;
   assign ram_we      = we && !win_hit;

   assign wr_tx     = we && win_hit && (offset == OFF_TXDATA);
   assign rd_status = !we && win_hit && (offset == OFF_STATUS);
   // A simultaneous pop frees the slot, so only an unaccompanied push to a full FIFO drops.
   assign drop      = wr_tx && fifo_full && !pop;

   z80_tx_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (clock),
      .rst_i  (reset),
      .push_i (wr_tx),
      .pop_i  (pop),
      .din_i  (data_i),
      .dout_o (fifo_dout),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   always_comb begin
      status             = '0;
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_BUSY]  = (state_q != IDLE);
      status[STAT_OVF]   = ovf_q;

      case (offset)
         OFF_TXDATA: rdata_d = 8'h00;
         OFF_STATUS: rdata_d = status;
         OFF_DIVLO:  rdata_d = div_q[7:0];
         default:    rdata_d = div_q[15:8];
      endcase

      ovf_d = drop ? 1'b1 : (rd_status ? 1'b0 : ovf_q);

      div_d = div_q;
      if (we && win_hit && offset == OFF_DIVLO) div_d[7:0]  = data_i;
      if (we && win_hit && offset == OFF_DIVHI) div_d[15:8] = data_i;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hit_q   <= 1'b0;
         rdata_q <= 8'h00;
         ovf_q   <= 1'b0;
         div_q   <= 16'(BAUD_DIV);
      end else begin
         hit_q   <= win_hit;
         rdata_q <= rdata_d;
         ovf_q   <= ovf_d;
         div_q   <= div_d;
      end
   end

   assign data_o = hit_q ? rdata_q : ram_data_i;

   // Transmitter: state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         fdiv_q  <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fdiv_q  <= fdiv_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   // Transmitter: next state; fdiv_q holds the frame's divisor so DIV writes wait a frame
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fdiv_d  = fdiv_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
               cnt_d   = div_q;
               fdiv_d  = div_q;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = fdiv_q;
               bit_d   = 3'd0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         DATA: begin
            if (cnt_q == 16'd0) begin
               cnt_d   = fdiv_q;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) state_d = STOP;
               else bit_d = bit_q + 3'd1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: begin
            if (cnt_q == 16'd0) state_d = IDLE;
            else cnt_d = cnt_q - 16'd1;
         end
      endcase
   end

   // Transmitter: output, registered so tx never glitches
   always_comb begin
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign tx = tx_q;

endmodule
